// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode values, ALUOp encodings and the
// hard-wired zero register index.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/decode_regfile_if.sv
// Decode-stage bus: instruction and write-back inputs, register operands,
// immediate and main control outputs.
interface decode_regfile_if;

    logic [31:0] Inst;
    logic        WbEn;
    logic [4:0]  WbAddr;
    logic [31:0] WbData;

    logic [31:0] RsData;
    logic [31:0] RtData;
    logic [31:0] ExtendSign;
    logic [4:0]  WriteReg;
    logic        RegDst;
    logic        RegWrite;
    logic        ALUSrc;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg;
    logic        Branch;
    logic        Jump;
    logic [1:0]  ALUOp;
    logic        Illegal;

    modport master (
        output Inst, WbEn, WbAddr, WbData,
        input  RsData, RtData, ExtendSign, WriteReg, RegDst, RegWrite, ALUSrc,
               MemRead, MemWrite, MemtoReg, Branch, Jump, ALUOp, Illegal
    );

    modport slave (
        input  Inst, WbEn, WbAddr, WbData,
        output RsData, RtData, ExtendSign, WriteReg, RegDst, RegWrite, ALUSrc,
               MemRead, MemWrite, MemtoReg, Branch, Jump, ALUOp, Illegal
    );

endinterface

// File: rtl/decode_regfile_reg_file32.sv
// 32-entry architectural register file: one write port, two combinational
// read ports with same-cycle write-through bypass, register 0 tied to zero.
module reg_file32
    import mips_pkg::*;
#(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [4:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [4:0]    rd_addr_a,
    input  logic [4:0]    rd_addr_b,
    output logic [DW-1:0] rd_data_a,
    output logic [DW-1:0] rd_data_b
);

    logic [DW-1:0] regs [NREG];
    logic          wr_live;

    assign wr_live = wr_en && (wr_addr != REG_ZERO);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Reset masks both the bypass and any stale array contents so reads are 0.
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        if (rst || rd_addr_a == REG_ZERO) begin
            rd_data_a = '0;
        end else if (wr_live && wr_addr == rd_addr_a) begin
            rd_data_a = wr_data;
        end
    end

    always_comb begin
        rd_data_b = regs[rd_addr_b];
        if (rst || rd_addr_b == REG_ZERO) begin
            rd_data_b = '0;
        end else if (wr_live && wr_addr == rd_addr_b) begin
            rd_data_b = wr_data;
        end
    end

endmodule

// File: rtl/decode_regfile.sv
// MIPS single-cycle decode stage: main control decoder, sign extension,
// destination mux, sticky illegal-opcode flag and the register file.
module decode_regfile
    import mips_pkg::*;
#(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input logic             clk,
    input logic             rst,
    decode_regfile_if.slave bus
);

    logic [5:0] opcode;
    logic       legal;
    logic       illegal_q;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;

    assign opcode = bus.Inst[31:26];

    always_comb begin
        legal      = 1'b1;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_op     = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            OP_LW: begin
                alu_src    = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            OP_SW: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OP_BEQ: begin
                branch = 1'b1;
                alu_op = ALU_SUB;
            end
            OP_ADDI: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
            end
            OP_J: begin
                jump = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // Sticky until reset; legal instructions never clear it.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (!legal) begin
            illegal_q <= 1'b1;
        end
    end

    reg_file32 #(
        .NREG(NREG),
        .DW  (DW)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (bus.WbEn),
        .wr_addr  (bus.WbAddr),
        .wr_data  (bus.WbData),
        .rd_addr_a(bus.Inst[25:21]),
        .rd_addr_b(bus.Inst[20:16]),
        .rd_data_a(bus.RsData),
        .rd_data_b(bus.RtData)
    );

    assign bus.ExtendSign = {{16{bus.Inst[15]}}, bus.Inst[15:0]};
    assign bus.WriteReg   = reg_dst ? bus.Inst[15:11] : bus.Inst[20:16];
    assign bus.RegDst     = reg_dst;
    assign bus.RegWrite   = reg_write;
    assign bus.ALUSrc     = alu_src;
    assign bus.MemRead    = mem_read;
    assign bus.MemWrite   = mem_write;
    assign bus.MemtoReg   = mem_to_reg;
    assign bus.Branch     = branch;
    assign bus.Jump       = jump;
    assign bus.ALUOp      = alu_op;
    assign bus.Illegal    = illegal_q;

endmodule

// File: tb/tb_decode_regfile.sv
// Self-checking bench for decode_regfile: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a reference model.
module tb_decode_regfile;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_regfile_if bus ();

    decode_regfile dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: architectural registers and the sticky flag.
    logic [31:0] m_regs [32];
    bit          m_ill = 1'b0;
    bit          model_live = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected control word {RegDst,RegWrite,ALUSrc,MemRead,MemWrite,MemtoReg,Branch,Jump,ALUOp}.
    function automatic logic [9:0] exp_ctrl(input logic [5:0] op);
        case (op)
            6'd0:  return 10'b1100000010;
            6'd35: return 10'b0111010000;
            6'd43: return 10'b0010100000;
            6'd4:  return 10'b0000001001;
            6'd8:  return 10'b0110000000;
            6'd2:  return 10'b0000000100;
            default: return 10'b0;
        endcase
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (rst || a == 0) return 32'h0;
        if (bus.WbEn && bus.WbAddr == a) return bus.WbData;
        return m_regs[a];
    endfunction

    function automatic logic [9:0] dut_ctrl();
        return {bus.RegDst, bus.RegWrite, bus.ALUSrc, bus.MemRead, bus.MemWrite,
                bus.MemtoReg, bus.Branch, bus.Jump, bus.ALUOp};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_ill = 1'b0;
            model_live = 1'b1;
        end else begin
            if (bus.WbEn && bus.WbAddr != 0) m_regs[bus.WbAddr] = bus.WbData;
            if (exp_ctrl(bus.Inst[31:26]) == 10'b0) m_ill = 1'b1;
        end
    end

    // Every-cycle comparison against the model once a reset has been seen.
    always @(negedge clk) begin
        if (model_live) begin
            logic [31:0] ins;
            logic [9:0]  c;
            ins = bus.Inst;
            c = exp_ctrl(ins[31:26]);
            check("m_rs", bus.RsData, exp_read(ins[25:21]));
            check("m_rt", bus.RtData, exp_read(ins[20:16]));
            check("m_ext", bus.ExtendSign, 32'($signed(ins[15:0])));
            check("m_wreg", {27'b0, bus.WriteReg}, {27'b0, c[9] ? ins[15:11] : ins[20:16]});
            check("m_ctrl", {22'b0, dut_ctrl()}, {22'b0, c});
            check("m_ill", {31'b0, bus.Illegal}, {31'b0, m_ill});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r;
        logic [5:0]  ops [8];
        ops[0] = 6'd0;  ops[1] = 6'd35; ops[2] = 6'd43; ops[3] = 6'd4;
        ops[4] = 6'd8;  ops[5] = 6'd2;  ops[6] = 6'h3F; ops[7] = 6'd1;

        // Reset then read
        rst = 1'b1;
        bus.Inst = 32'h012A4020;
        bus.WbEn = 1'b0;
        bus.WbAddr = 5'd0;
        bus.WbData = 32'h0;
        @(negedge clk);
        check("rst_rs", bus.RsData, 32'h0);
        check("rst_rt", bus.RtData, 32'h0);
        check("rst_ctrl", {22'b0, dut_ctrl()}, {22'b0, 10'b1100000010});
        check("rst_wreg", {27'b0, bus.WriteReg}, 32'd8);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rs", bus.RsData, 32'h0);
        check("post_rst_ill", {31'b0, bus.Illegal}, 32'd0);

        // Write with bypass, then from the array
        step();
        bus.WbEn = 1'b1; bus.WbAddr = 5'd9; bus.WbData = 32'hDEADBEEF;
        @(negedge clk);
        check("bypass_rs", bus.RsData, 32'hDEADBEEF);
        step();
        bus.WbEn = 1'b0;
        @(negedge clk);
        check("array_rs", bus.RsData, 32'hDEADBEEF);

        // Register zero
        step();
        bus.Inst = 32'h00004020;
        bus.WbEn = 1'b1; bus.WbAddr = 5'd0; bus.WbData = 32'hFFFFFFFF;
        @(negedge clk);
        check("r0_bypass", bus.RsData, 32'h0);
        step();
        bus.WbEn = 1'b0;
        @(negedge clk);
        check("r0_array", bus.RsData, 32'h0);

        // Immediate, branch, load
        step();
        bus.Inst = 32'h1109FFFE;
        @(negedge clk);
        check("beq_branch", {31'b0, bus.Branch}, 32'd1);
        check("beq_aluop", {30'b0, bus.ALUOp}, 32'd1);
        check("beq_ext", bus.ExtendSign, 32'hFFFFFFFE);
        step();
        bus.Inst = 32'h8D2A0010;
        @(negedge clk);
        check("lw_ext", bus.ExtendSign, 32'h00000010);
        check("lw_memread", {31'b0, bus.MemRead}, 32'd1);
        check("lw_memtoreg", {31'b0, bus.MemtoReg}, 32'd1);
        check("lw_wreg", {27'b0, bus.WriteReg}, 32'd10);
        check("lw_rs", bus.RsData, 32'hDEADBEEF);

        // Illegal opcode, then sticky through a jump
        step();
        bus.Inst = 32'hFC000000;
        @(negedge clk);
        check("ill_ctrl", {22'b0, dut_ctrl()}, 32'd0);
        check("ill_before", {31'b0, bus.Illegal}, 32'd0);
        step();
        bus.Inst = 32'h08000004;
        @(negedge clk);
        check("j_jump", {31'b0, bus.Jump}, 32'd1);
        check("ill_after", {31'b0, bus.Illegal}, 32'd1);
        step();
        @(negedge clk);
        check("ill_sticky", {31'b0, bus.Illegal}, 32'd1);

        // Reset mid-write
        step();
        bus.Inst = 32'h00A00000;
        bus.WbEn = 1'b1; bus.WbAddr = 5'd5; bus.WbData = 32'h55;
        step();
        rst = 1'b1;
        bus.WbData = 32'h1234;
        @(negedge clk);
        check("rstw_during", bus.RsData, 32'h0);
        step();
        rst = 1'b0;
        bus.WbEn = 1'b0;
        @(negedge clk);
        check("rstw_after", bus.RsData, 32'h0);
        check("rstw_ill", {31'b0, bus.Illegal}, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            step();
            r = $urandom();
            bus.Inst = {ops[$urandom_range(7)], r[25:0]};
            bus.WbEn = ($urandom_range(3) != 0);
            bus.WbAddr = ($urandom_range(3) == 0) ? r[25:21] : 5'($urandom_range(31));
            bus.WbData = $urandom();
            rst = ($urandom_range(99) == 0);
        end
        step();
        rst = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
